ds_bypass_slot: RTL and testbench
=================================

# ds_bypass_slot

Parametrised decode-stage pipeline slot with operand bypass and interlock, the successor to the fixed stall-only decode handshake. It holds one instruction beat between fetch and execute, resolves up to NSRC register source operands against NFWD downstream write ports (youngest first), and stalls only when the matching producer's data is not yet available. It sits between the fetch stage and the execute stage; decode field extraction stays outside, and this block owns the valid/allowin handshake, operand selection and a stall counter.

## Interface
- DW, 64: width of the fetch-to-decode bus (pc + inst) captured in the slot
- XLEN, 32: register data width
- AW, 5: register address width; address 0 is hardwired zero
- NSRC, 2: number of source operands resolved
- NFWD, 3: number of forwarding ports; index 0 is youngest (EX), NFWD-1 oldest (WB)
- CW, 16: stall counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- fs_to_ds_valid  in  1  upstream beat valid
- fs_to_ds_bus  in  DW  upstream beat payload
- ds_allowin  out  1  slot can accept a beat this cycle
- es_allowin  in  1  downstream can accept
- ds_to_es_valid  out  1  slot beat is valid and operands resolved
- ds_bus  out  DW  registered payload
- flush  in  1  discard slot contents
- src_addr  in  NSRC*AW  source register addresses, decoded from ds_bus by external logic
- src_used  in  NSRC  operand i is actually read by the instruction
- rf_rdata  in  NSRC*XLEN  register file read data per source
- fwd_valid  in  NFWD  port k holds a valid instruction
- fwd_we  in  NFWD  port k writes the register file
- fwd_waddr  in  NFWD*AW  port k destination
- fwd_data_ok  in  NFWD  port k result is available (0 for a load in EX, etc.)
- fwd_wdata  in  NFWD*XLEN  port k result
- src_data  out  NSRC*XLEN  resolved operands
- stall_cnt  out  CW  saturating count of hazard-stall cycles

## Operation
- Slot state: ds_valid (1 bit), bus register (DW), stall counter (CW).
- Match: port k matches source i when src_used[i] && fwd_valid[k] && fwd_we[k] && fwd_waddr[k]==src_addr[i] && src_addr[i]!=0.
- Selection per source: the lowest-index matching port wins; src_data[i] = that port's fwd_wdata; with no match, src_data[i] = rf_rdata[i]. src_addr 0 always yields rf_rdata (expected zero).
- Hazard: source i is blocked when its winning port has fwd_data_ok=0. An older port with data_ok=1 never bypasses a blocked younger match.
- ready_go = no source blocked.
- ds_to_es_valid = ds_valid && ready_go && !flush.
- ds_allowin = !ds_valid || (ready_go && es_allowin) || flush.
- Next ds_valid: flush -> 0; else if ds_allowin -> fs_to_ds_valid; else hold.
- Bus register loads fs_to_ds_bus when ds_allowin && fs_to_ds_valid && !flush; otherwise it holds.
- stall_cnt increments by 1 each cycle with ds_valid && !ready_go && !flush, and saturates at 2^CW-1 (no wrap).
- Fully parametric: no hardcoded stage names; NFWD=1, NSRC=1 must elaborate.

## Timing
- Reset (async assert): ds_valid=0, ds_bus=0, stall_cnt=0; therefore ds_to_es_valid=0 and ds_allowin=1. Deassertion is taken synchronously on the next edge.
- Latency: a beat accepted at edge N is presented at ds_to_es_valid in cycle N+1 if there is no hazard.
- Operand selection, ready_go and the handshake outputs are combinational from the current inputs and state. There is no registered bypass.
- Throughput: 1 beat/cycle with back-to-back acceptance when es_allowin=1 and there are no hazards.
- Downstream backpressure (es_allowin=0) holds the slot and payload stable, and does not count as a stall.
- Flush concurrent with fs_to_ds_valid: the incoming beat is dropped and ds_valid=0 next cycle.
- Flush during a hazard stall: the slot is cleared and the counter does not increment that cycle.
- Reset asserted mid-stall: all state clears immediately, without waiting for a clock edge.

## Test plan
- Reset, then a beat with pc=0x1000 and no matches: ds_to_es_valid=1 one cycle after acceptance, src_data=rf_rdata, stall_cnt=0.
- EX (k=0) writes r5=0xAAAA with data_ok=1, and WB (k=2) writes r5=0x5555; source 0 reads r5: src_data[0]=0xAAAA, no stall.
- Load in EX to r7 with data_ok=0, and source 1 reads r7: ds_to_es_valid=0 and ds_allowin=0 for 2 cycles (stall_cnt=2). When data_ok rises with 0x1234, src_data[1]=0x1234 and the beat issues.
- src_addr=0 while a port writes r0=0xFFFF: src_data=rf_rdata (0) and no stall. A source with src_used=0 that matches a blocked port does not stall.
- Stall with flush asserted while fs_to_ds_valid=1: next cycle ds_valid=0, the incoming beat is discarded, and stall_cnt is unchanged.
- With CW=2, force 5 stall cycles: stall_cnt reads 1,2,3,3,3. Async reset mid-stall clears all outputs before the next edge.

Source files
------------

// File: rtl/ds_bypass_slot.sv
// Decode-stage pipeline slot: holds one fetch beat, bypasses source operands from
// downstream write ports (youngest wins), interlocks on unready producers, counts stalls.
module ds_bypass_slot #(
  parameter int DW   = 64,
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NSRC = 2,
  parameter int NFWD = 3,
  parameter int CW   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fs_to_ds_valid,
  input  logic [DW-1:0]        fs_to_ds_bus,
  output logic                 ds_allowin,
  input  logic                 es_allowin,
  output logic                 ds_to_es_valid,
  output logic [DW-1:0]        ds_bus,
  input  logic                 flush,
  input  logic [NSRC*AW-1:0]   src_addr,
  input  logic [NSRC-1:0]      src_used,
  input  logic [NSRC*XLEN-1:0] rf_rdata,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_waddr,
  input  logic [NFWD-1:0]      fwd_data_ok,
  input  logic [NFWD*XLEN-1:0] fwd_wdata,
  output logic [NSRC*XLEN-1:0] src_data,
  output logic [CW-1:0]        stall_cnt
);

  logic            ds_valid;
  logic [NSRC-1:0] blocked;
  logic            ready_go;

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    src_data = rf_rdata;
    blocked  = '0;
    for (int i = 0; i < NSRC; i++) begin
      // Scan oldest to youngest: the youngest matching port is written last and wins,
      // including its data_ok, so an older ready port never hides a blocked younger one.
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (src_used[i] && fwd_valid[k] && fwd_we[k] &&
            src_addr[i*AW +: AW] != '0 &&
            fwd_waddr[k*AW +: AW] == src_addr[i*AW +: AW]) begin
          src_data[i*XLEN +: XLEN] = fwd_wdata[k*XLEN +: XLEN];
          blocked[i]               = !fwd_data_ok[k];
        end
      end
    end
  end

  assign ready_go       = ~|blocked;
  assign ds_to_es_valid = ds_valid && ready_go && !flush;
  assign ds_allowin     = !ds_valid || (ready_go && es_allowin) || flush;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid  <= 1'b0;
      ds_bus    <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush)
        ds_valid <= 1'b0;
      else if (ds_allowin)
        ds_valid <= fs_to_ds_valid;

      if (ds_allowin && fs_to_ds_valid && !flush)
        ds_bus <= fs_to_ds_bus;

      // Only hazard stalls count; backpressure and flushed cycles do not.
      if (ds_valid && !ready_go && !flush && stall_cnt != {CW{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ds_bypass_slot.sv
// Self-checking bench for ds_bypass_slot: a spec-level model compared every cycle,
// directed hazard/flush/backpressure vectors, and a CW=2 single-port instance for saturation.
module tb_ds_bypass_slot;
  localparam int DW = 64, XLEN = 32, AW = 5, NSRC = 2, NFWD = 3, CW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                 fs_to_ds_valid, es_allowin, flush;
  logic [DW-1:0]        fs_to_ds_bus;
  logic                 ds_allowin, ds_to_es_valid;
  logic [DW-1:0]        ds_bus;
  logic [NSRC*AW-1:0]   src_addr;
  logic [NSRC-1:0]      src_used;
  logic [NSRC*XLEN-1:0] rf_rdata, src_data;
  logic [NFWD-1:0]      fwd_valid, fwd_we, fwd_data_ok;
  logic [NFWD*AW-1:0]   fwd_waddr;
  logic [NFWD*XLEN-1:0] fwd_wdata;
  logic [CW-1:0]        stall_cnt;

  // Stimulus kept as per-source / per-port arrays, packed onto the DUT buses.
  logic [AW-1:0]   t_addr [NSRC];
  logic            t_used [NSRC];
  logic [XLEN-1:0] t_rf   [NSRC];
  logic            t_fv   [NFWD];
  logic            t_fwe  [NFWD];
  logic [AW-1:0]   t_fwa  [NFWD];
  logic            t_fok  [NFWD];
  logic [XLEN-1:0] t_fwd  [NFWD];

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign src_addr[i*AW +: AW]     = t_addr[i];
    assign src_used[i]              = t_used[i];
    assign rf_rdata[i*XLEN +: XLEN] = t_rf[i];
  end
  for (genvar k = 0; k < NFWD; k++) begin : g_fwd
    assign fwd_valid[k]              = t_fv[k];
    assign fwd_we[k]                 = t_fwe[k];
    assign fwd_waddr[k*AW +: AW]     = t_fwa[k];
    assign fwd_data_ok[k]            = t_fok[k];
    assign fwd_wdata[k*XLEN +: XLEN] = t_fwd[k];
  end

  ds_bypass_slot #(.DW(DW), .XLEN(XLEN), .AW(AW), .NSRC(NSRC), .NFWD(NFWD), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .ds_allowin(ds_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_bus(ds_bus), .flush(flush),
    .src_addr(src_addr), .src_used(src_used), .rf_rdata(rf_rdata),
    .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_data_ok(fwd_data_ok), .fwd_wdata(fwd_wdata),
    .src_data(src_data), .stall_cnt(stall_cnt)
  );

  // Minimal configuration: one source, one port, 2-bit counter; sees source 0 / port 0.
  logic            s_ds_allowin, s_ds_to_es_valid;
  logic [DW-1:0]   s_ds_bus;
  logic [XLEN-1:0] s_src_data;
  logic [1:0]      s_stall_cnt;

  ds_bypass_slot #(.DW(DW), .XLEN(XLEN), .AW(AW), .NSRC(1), .NFWD(1), .CW(2)) dut_s (
    .clk(clk), .reset(reset),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .ds_allowin(s_ds_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(s_ds_to_es_valid), .ds_bus(s_ds_bus), .flush(flush),
    .src_addr(src_addr[AW-1:0]), .src_used(src_used[0]), .rf_rdata(rf_rdata[XLEN-1:0]),
    .fwd_valid(fwd_valid[0]), .fwd_we(fwd_we[0]), .fwd_waddr(fwd_waddr[AW-1:0]),
    .fwd_data_ok(fwd_data_ok[0]), .fwd_wdata(fwd_wdata[XLEN-1:0]),
    .src_data(s_src_data), .stall_cnt(s_stall_cnt)
  );

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_bus   = '0;
  logic [CW-1:0] m_cnt   = '0;

  function automatic bit port_hits(int i, int k);
    return t_used[i] && t_fv[k] && t_fwe[k] && t_addr[i] != 0 && t_fwa[k] == t_addr[i];
  endfunction

  // Youngest (lowest index) matching port supplies the operand, else the register file.
  function automatic logic [XLEN-1:0] exp_src(int i);
    for (int k = 0; k < NFWD; k++)
      if (port_hits(i, k)) return t_fwd[k];
    return t_rf[i];
  endfunction

  function automatic bit exp_blocked(int i);
    for (int k = 0; k < NFWD; k++)
      if (port_hits(i, k)) return !t_fok[k];
    return 1'b0;
  endfunction

  function automatic bit exp_ready();
    for (int i = 0; i < NSRC; i++)
      if (exp_blocked(i)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_allowin();
    return !m_valid || (exp_ready() && es_allowin) || flush;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_bus   <= '0;
      m_cnt   <= '0;
    end else begin
      if (m_valid && !exp_ready() && !flush && m_cnt != {CW{1'b1}}) m_cnt <= m_cnt + 1'b1;
      if (flush) m_valid <= 1'b0;
      else if (exp_allowin()) m_valid <= fs_to_ds_valid;
      if (exp_allowin() && fs_to_ds_valid && !flush) m_bus <= fs_to_ds_bus;
    end
  end

  always @(negedge clk) begin
    check("m_valid_out", ds_to_es_valid, m_valid && exp_ready() && !flush);
    check("m_allowin", ds_allowin, exp_allowin());
    check("m_bus", ds_bus, m_bus);
    check("m_stall_cnt", stall_cnt, m_cnt);
    for (int i = 0; i < NSRC; i++) check("m_src_data", src_data[i*XLEN +: XLEN], exp_src(i));
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [DW-1:0] mk(input logic [31:0] pc);
    return {pc, 32'h0000_0013};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_fwd();
    for (int k = 0; k < NFWD; k++) begin
      t_fv[k] = 0; t_fwe[k] = 0; t_fwa[k] = '0; t_fok[k] = 1; t_fwd[k] = '0;
    end
    for (int i = 0; i < NSRC; i++) begin
      t_used[i] = 0; t_addr[i] = '0; t_rf[i] = '0;
    end
  endtask

  task automatic set_port(input int k, input logic [AW-1:0] wa, input logic ok,
                          input logic [XLEN-1:0] d);
    t_fv[k] = 1; t_fwe[k] = 1; t_fwa[k] = wa; t_fok[k] = ok; t_fwd[k] = d;
  endtask

  task automatic set_src(input int i, input logic used, input logic [AW-1:0] a,
                         input logic [XLEN-1:0] rf);
    t_used[i] = used; t_addr[i] = a; t_rf[i] = rf;
  endtask

  task automatic send(input logic [31:0] pc);
    fs_to_ds_valid = 1; fs_to_ds_bus = mk(pc);
    tick();
    fs_to_ds_valid = 0;
  endtask

  initial begin
    reset = 1; flush = 0; es_allowin = 1; fs_to_ds_valid = 0; fs_to_ds_bus = '0;
    idle_fwd();
    tick(); tick();
    check("rst_valid", ds_to_es_valid, 0);
    check("rst_allowin", ds_allowin, 1);
    check("rst_bus", ds_bus, 0);
    check("rst_cnt", stall_cnt, 0);
    reset = 0;
    tick();

    // Plain beat, no matches: issues the cycle after acceptance with rf data.
    set_src(0, 1, 5'd1, 32'h11); set_src(1, 1, 5'd2, 32'h22);
    send(32'h1000);
    #1;
    check("beat_valid", ds_to_es_valid, 1);
    check("beat_bus", ds_bus, 64'h0000_1000_0000_0013);
    check("beat_src0", src_data[31:0], 32'h11);
    check("beat_src1", src_data[63:32], 32'h22);
    check("beat_cnt", stall_cnt, 0);

    // EX and WB both write r5: the EX value wins.
    send(32'h1004);
    idle_fwd();
    set_port(0, 5'd5, 1, 32'hAAAA); set_port(2, 5'd5, 1, 32'h5555);
    set_src(0, 1, 5'd5, 32'h99);
    #1;
    check("fwd_src0", src_data[31:0], 32'hAAAA);
    check("fwd_valid", ds_to_es_valid, 1);
    tick();

    // Load in EX to r7 not ready: two stall cycles, then data arrives.
    idle_fwd();
    send(32'h1008);
    set_port(0, 5'd7, 0, 32'hDEAD); set_port(2, 5'd7, 1, 32'h5555);
    set_src(1, 1, 5'd7, 32'h77);
    #1;
    check("ld_valid", ds_to_es_valid, 0);
    check("ld_allowin", ds_allowin, 0);
    tick();
    check("ld_cnt1", stall_cnt, 1);
    check("ld_allowin1", ds_allowin, 0);
    tick();
    check("ld_cnt2", stall_cnt, 2);
    check("ld_valid2", ds_to_es_valid, 0);
    t_fok[0] = 1; t_fwd[0] = 32'h1234;
    #1;
    check("ld_src1", src_data[63:32], 32'h1234);
    check("ld_issue", ds_to_es_valid, 1);
    check("ld_allowin3", ds_allowin, 1);
    tick();
    check("ld_cnt_hold", stall_cnt, 2);

    // r0 never forwards; an unused source matching a blocked port does not stall.
    idle_fwd();
    send(32'h100C);
    set_port(1, 5'd0, 0, 32'hFFFF); set_port(0, 5'd9, 0, 32'hBEEF);
    set_src(0, 1, 5'd0, 32'h0); set_src(1, 0, 5'd9, 32'h44);
    #1;
    check("r0_src0", src_data[31:0], 32'h0);
    check("unused_src1", src_data[63:32], 32'h44);
    check("r0_valid", ds_to_es_valid, 1);
    tick();
    check("r0_cnt", stall_cnt, 2);

    // Flush during a hazard stall with a new beat arriving: beat dropped, count held.
    idle_fwd();
    send(32'h1010);
    set_port(0, 5'd3, 0, 32'h0); set_src(0, 1, 5'd3, 32'h0);
    tick();
    check("fl_pre_cnt", stall_cnt, 3);
    flush = 1; fs_to_ds_valid = 1; fs_to_ds_bus = mk(32'h2000);
    #1;
    check("fl_valid", ds_to_es_valid, 0);
    check("fl_allowin", ds_allowin, 1);
    tick();
    flush = 0; fs_to_ds_valid = 0;
    #1;
    check("fl_cnt", stall_cnt, 3);
    check("fl_empty", ds_to_es_valid, 0);
    check("fl_bus", ds_bus, 64'h0000_1010_0000_0013);

    // Backpressure holds payload and does not count; then back-to-back beats.
    idle_fwd();
    send(32'h3000);
    es_allowin = 0; fs_to_ds_valid = 1; fs_to_ds_bus = mk(32'h3004);
    #1;
    check("bp_allowin", ds_allowin, 0);
    check("bp_valid", ds_to_es_valid, 1);
    tick();
    check("bp_bus", ds_bus, 64'h0000_3000_0000_0013);
    check("bp_cnt", stall_cnt, 3);
    es_allowin = 1;
    tick();
    check("b2b_bus0", ds_bus, 64'h0000_3004_0000_0013);
    fs_to_ds_bus = mk(32'h3008);
    tick();
    check("b2b_bus1", ds_bus, 64'h0000_3008_0000_0013);
    check("b2b_valid", ds_to_es_valid, 1);
    fs_to_ds_valid = 0;
    tick();
    check("b2b_drain", ds_to_es_valid, 0);

    // Saturation of the 2-bit counter, then async reset mid-stall.
    reset = 1;
    tick();
    reset = 0;
    tick();
    send(32'h4000);
    set_port(0, 5'd7, 0, 32'h0); set_src(0, 1, 5'd7, 32'h0);
    tick(); check("sat_1", s_stall_cnt, 1);
    tick(); check("sat_2", s_stall_cnt, 2);
    tick(); check("sat_3", s_stall_cnt, 3);
    tick(); check("sat_4", s_stall_cnt, 3);
    tick(); check("sat_5", s_stall_cnt, 3);
    check("sat_main", stall_cnt, 5);
    #1 reset = 1;
    #1;
    check("ar_valid", ds_to_es_valid, 0);
    check("ar_allowin", ds_allowin, 1);
    check("ar_cnt", stall_cnt, 0);
    check("ar_bus", ds_bus, 0);
    check("ar_s_cnt", s_stall_cnt, 0);
    check("ar_s_allowin", s_ds_allowin, 1);
    tick();
    reset = 0;
    idle_fwd();
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
